// File: rtl/osd_regaccess_initiator.sv
// osd_regaccess_initiator
// Issues one register read/write at a time to a status/control responder on
// the debug ring and returns the parsed result to the local command source.
//
// Handshake rule for every channel here (cmd, rsp, debug_out, debug_in):
// a transfer happens on the rising edge where valid and ready are both 1;
// a producer holds valid and its payload stable until that edge, and a
// consumer may raise or drop ready at any time.
module osd_regaccess_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [9:0]  id_i,

    output logic [15:0] debug_out_data_o,
    output logic        debug_out_valid_o,
    output logic        debug_out_last_o,
    input  logic        debug_out_ready_i,

    input  logic [15:0] debug_in_data_i,
    input  logic        debug_in_valid_i,
    input  logic        debug_in_last_i,
    output logic        debug_in_ready_o,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [9:0]  cmd_dest_i,
    input  logic [15:0] cmd_addr_i,
    input  logic [15:0] cmd_wdata_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_error_o,
    output logic        rsp_timeout_o,
    output logic [15:0] rsp_rdata_o,

    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        ST_IDLE          = 4'd0,
        ST_REQ_DEST      = 4'd1,
        ST_REQ_HDR       = 4'd2,
        ST_REQ_ADDR      = 4'd3,
        ST_REQ_WDATA     = 4'd4,
        ST_RSP_DEST      = 4'd5,
        ST_RSP_HDR       = 4'd6,
        ST_RSP_VALUE     = 4'd7,
        ST_RSP_DROP      = 4'd8,
        ST_RSP_DROP_DONE = 4'd9,
        ST_DONE          = 4'd10
    } state_t;

    // Size field of the request header: always a 16-bit access.
    localparam logic [1:0] SIZE_16 = 2'b01;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [9:0]  dest_q, dest_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        tmo_q, tmo_d;
    logic [15:0] rdata_q, rdata_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] cnt_inc;
    logic        hdr_foreign;
    logic        timeout_hit;

    // Saturating increment: the wait counter never wraps back to zero.
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 32'd1;

    // The timeout fires on the cycle in which the counter reaches the limit,
    // so a limit of N ends the wait after N cycles in the response phase.
    // Using >= keeps the guard effective if the limit was passed while a
    // foreign packet was being drained.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc >= TIMEOUT_CYCLES);

    // A response header belongs to us only if it comes from the addressed
    // module and echoes the access direction we requested.
    assign hdr_foreign = (debug_in_data_i[9:0] != dest_q) ||
                         (debug_in_data_i[11] != write_q);

    assign rsp_error_o   = err_q;
    assign rsp_timeout_o = tmo_q;
    assign rsp_rdata_o   = rdata_q;
    assign state_o       = state_q;

    // State and datapath registers; synchronous reset abandons any packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            dest_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            dest_q  <= dest_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, request serialisation and response parsing.
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        dest_d  = dest_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;

        debug_out_valid_o = 1'b0;
        debug_out_data_o  = 16'h0000;
        debug_out_last_o  = 1'b0;
        debug_in_ready_o  = 1'b0;
        cmd_ready_o       = 1'b0;
        rsp_valid_o       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                // Stray words arriving while idle are swallowed.
                debug_in_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    write_d = cmd_write_i;
                    dest_d  = cmd_dest_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    err_d   = 1'b0;
                    tmo_d   = 1'b0;
                    rdata_d = 16'h0000;
                    state_d = ST_REQ_DEST;
                end
            end

            ST_REQ_DEST: begin
                debug_out_valid_o = 1'b1;
                debug_out_data_o  = {6'h00, dest_q};
                if (debug_out_ready_i) begin
                    state_d = ST_REQ_HDR;
                end
            end

            ST_REQ_HDR: begin
                debug_out_valid_o = 1'b1;
                // {type=00, burst=0, write, size, source=own id}
                debug_out_data_o  = {2'b00, 1'b0, write_q, SIZE_16, id_i};
                if (debug_out_ready_i) begin
                    state_d = ST_REQ_ADDR;
                end
            end

            ST_REQ_ADDR: begin
                debug_out_valid_o = 1'b1;
                debug_out_data_o  = addr_q;
                debug_out_last_o  = ~write_q;
                if (debug_out_ready_i) begin
                    if (write_q) begin
                        state_d = ST_REQ_WDATA;
                    end else begin
                        cnt_d   = 32'd0;
                        state_d = ST_RSP_DEST;
                    end
                end
            end

            ST_REQ_WDATA: begin
                debug_out_valid_o = 1'b1;
                debug_out_data_o  = wdata_q;
                debug_out_last_o  = 1'b1;
                if (debug_out_ready_i) begin
                    cnt_d   = 32'd0;
                    state_d = ST_RSP_DEST;
                end
            end

            ST_RSP_DEST: begin
                debug_in_ready_o = 1'b1;
                cnt_d            = cnt_inc;
                if (debug_in_valid_i) begin
                    // A one-word packet carries no header; drop it.
                    if (!debug_in_last_i) begin
                        state_d = ST_RSP_HDR;
                    end
                end else if (timeout_hit) begin
                    // Only between packets, so a packet is never cut.
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    rdata_d = 16'h0000;
                    state_d = ST_DONE;
                end
            end

            ST_RSP_HDR: begin
                debug_in_ready_o = 1'b1;
                cnt_d            = cnt_inc;
                if (debug_in_valid_i) begin
                    if (hdr_foreign) begin
                        state_d = debug_in_last_i ? ST_RSP_DEST : ST_RSP_DROP;
                    end else if (debug_in_data_i[10] || write_q) begin
                        // Write ack or error: header must end the packet.
                        err_d   = debug_in_data_i[10] | ~debug_in_last_i;
                        rdata_d = 16'h0000;
                        state_d = debug_in_last_i ? ST_DONE : ST_RSP_DROP_DONE;
                    end else if (debug_in_last_i) begin
                        // Successful read without a value word.
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RSP_VALUE;
                    end
                end
            end

            ST_RSP_VALUE: begin
                debug_in_ready_o = 1'b1;
                cnt_d            = cnt_inc;
                if (debug_in_valid_i) begin
                    if (debug_in_last_i) begin
                        rdata_d = debug_in_data_i;
                        state_d = ST_DONE;
                    end else begin
                        // Overlong read response: report error, no value.
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                        state_d = ST_RSP_DROP_DONE;
                    end
                end
            end

            ST_RSP_DROP: begin
                debug_in_ready_o = 1'b1;
                cnt_d            = cnt_inc;
                if (debug_in_valid_i && debug_in_last_i) begin
                    state_d = ST_RSP_DEST;
                end
            end

            ST_RSP_DROP_DONE: begin
                debug_in_ready_o = 1'b1;
                cnt_d            = cnt_inc;
                if (debug_in_valid_i && debug_in_last_i) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_osd_regaccess_initiator.sv
// Directed bench for osd_regaccess_initiator: read, write, error, foreign
// packet with a throttled ring, timeout, and reset during a request.
module tb_osd_regaccess_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  id = 10'h005;

    logic [15:0] debug_out_data;
    logic        debug_out_valid;
    logic        debug_out_last;
    logic        debug_out_ready = 1'b0;

    logic [15:0] debug_in_data = 16'h0;
    logic        debug_in_valid = 1'b0;
    logic        debug_in_last = 1'b0;
    logic        debug_in_ready;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [9:0]  cmd_dest = 10'h0;
    logic [15:0] cmd_addr = 16'h0;
    logic [15:0] cmd_wdata = 16'h0;

    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [15:0] rsp_rdata;
    logic [3:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    // Expected request words, {last, data}.
    logic [16:0] exp_q[$];

    osd_regaccess_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .id_i              (id),
        .debug_out_data_o  (debug_out_data),
        .debug_out_valid_o (debug_out_valid),
        .debug_out_last_o  (debug_out_last),
        .debug_out_ready_i (debug_out_ready),
        .debug_in_data_i   (debug_in_data),
        .debug_in_valid_i  (debug_in_valid),
        .debug_in_last_i   (debug_in_last),
        .debug_in_ready_o  (debug_in_ready),
        .cmd_valid_i       (cmd_valid),
        .cmd_ready_o       (cmd_ready),
        .cmd_write_i       (cmd_write),
        .cmd_dest_i        (cmd_dest),
        .cmd_addr_i        (cmd_addr),
        .cmd_wdata_i       (cmd_wdata),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_error_o       (rsp_error),
        .rsp_timeout_o     (rsp_timeout),
        .rsp_rdata_o       (rsp_rdata),
        .state_o           (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Hard stop in case a wait is never satisfied.
    initial begin
        #500000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a command (called at a falling edge) and wait for acceptance.
    task automatic send_cmd(input logic w, input logic [9:0] d, input logic [15:0] a,
                            input logic [15:0] wd);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_dest  = d;
        cmd_addr  = a;
        cmd_wdata = wd;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_wait", n, 0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_dest  = 10'h0;
        cmd_addr  = 16'h0;
        cmd_wdata = 16'h0;
        check("cmd_busy", cmd_ready, 0);
    endtask

    // Sink request words, optionally toggling ready every cycle.
    task automatic recv_req(input int nwords, input bit toggle, output int cycles);
        int got = 0;
        int cyc = 0;
        bit phase = 1'b0;
        bit held = 1'b0;
        logic [16:0] held_w = '0;
        logic [16:0] e;
        while (got < nwords && cyc < 100) begin
            debug_out_ready = toggle ? phase : 1'b1;
            phase = ~phase;
            if (held) begin
                check("req_hold_stable", {15'h0, debug_out_last, debug_out_data}, {15'h0, held_w});
            end
            held = 1'b0;
            if (debug_out_valid) begin
                if (debug_out_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1ffff;
                    check("req_word", {15'h0, debug_out_last, debug_out_data}, {15'h0, e});
                    got++;
                end else begin
                    held   = 1'b1;
                    held_w = {debug_out_last, debug_out_data};
                end
            end
            @(negedge clk);
            cyc++;
        end
        debug_out_ready = 1'b0;
        check("req_word_count", got, nwords);
        cycles = cyc;
    endtask

    // Drive one response word and wait for it to be taken.
    task automatic send_word(input logic [15:0] d, input logic l);
        int n = 0;
        debug_in_valid = 1'b1;
        debug_in_data  = d;
        debug_in_last  = l;
        while (debug_in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_word_taken", (n < 100), 1);
        @(negedge clk);
        debug_in_valid = 1'b0;
        debug_in_data  = 16'h0;
        debug_in_last  = 1'b0;
    endtask

    // Scoreboard for the result: must be present now, hold, then release.
    task automatic expect_rsp(input string tag, input logic err, input logic to,
                              input logic [15:0] rd);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_error"}, rsp_error, err);
        check({tag, "_timeout"}, rsp_timeout, to);
        check({tag, "_rdata"}, rsp_rdata, rd);
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_hold"}, {rsp_valid, rsp_error, rsp_timeout, rsp_rdata},
              {13'h0, 1'b1, err, to, rd});
        check({tag, "_cmd_blocked"}, cmd_ready, 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_released"}, rsp_valid, 0);
        check({tag, "_cmd_ready_back"}, cmd_ready, 1);
    endtask

    initial begin
        int cyc;
        int k;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_state", {cmd_ready, debug_out_valid, debug_out_last, debug_in_ready,
                              rsp_valid, rsp_error, rsp_timeout},
              {25'h0, 7'b1001000});
        check("reset_out_data", debug_out_data, 16'h0000);
        check("reset_rdata", rsp_rdata, 16'h0000);

        // Read, everything ready
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h0405});
        exp_q.push_back({1'b1, 16'h0000});
        send_cmd(1'b0, 10'h012, 16'h0000, 16'hFFFF);
        check("w0_latency", debug_out_valid, 1);
        recv_req(3, 1'b0, cyc);
        check("read_req_cycles", cyc, 3);
        check("idle_out_valid", debug_out_valid, 0);
        check("idle_out_data", debug_out_data, 16'h0000);
        send_word(16'h0005, 1'b0);
        send_word(16'h0012, 1'b0);
        send_word(16'h4000, 1'b1);
        expect_rsp("read", 1'b0, 1'b0, 16'h4000);

        // Write, back-to-back with the previous result handshake
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h1405});
        exp_q.push_back({1'b0, 16'h0003});
        exp_q.push_back({1'b1, 16'h0801});
        send_cmd(1'b1, 10'h012, 16'h0003, 16'h0801);
        recv_req(4, 1'b0, cyc);
        check("write_req_cycles", cyc, 4);
        send_word(16'h0005, 1'b0);
        send_word(16'h0812, 1'b1);
        expect_rsp("write", 1'b0, 1'b0, 16'h0000);

        // Error response to a read
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h0405});
        exp_q.push_back({1'b1, 16'h0009});
        send_cmd(1'b0, 10'h012, 16'h0009, 16'h0000);
        recv_req(3, 1'b0, cyc);
        send_word(16'h0005, 1'b0);
        send_word(16'h0412, 1'b1);
        expect_rsp("err", 1'b1, 1'b0, 16'h0000);

        // Malformed: successful read header ends the packet
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h0405});
        exp_q.push_back({1'b1, 16'h000A});
        send_cmd(1'b0, 10'h012, 16'h000A, 16'h0000);
        recv_req(3, 1'b0, cyc);
        send_word(16'h0005, 1'b0);
        send_word(16'h0012, 1'b1);
        expect_rsp("short", 1'b1, 1'b0, 16'h0000);

        // Foreign packet first, ring ready toggling each cycle
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h0405});
        exp_q.push_back({1'b1, 16'h0007});
        send_cmd(1'b0, 10'h012, 16'h0007, 16'h0000);
        recv_req(3, 1'b1, cyc);
        send_word(16'h0005, 1'b0);
        send_word(16'h0033, 1'b0);
        send_word(16'h1111, 1'b1);
        check("foreign_no_rsp", rsp_valid, 0);
        send_word(16'h0005, 1'b0);
        send_word(16'h0012, 1'b0);
        send_word(16'h5A5A, 1'b1);
        expect_rsp("foreign", 1'b0, 1'b0, 16'h5A5A);

        // Timeout: no response at all
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h0405});
        exp_q.push_back({1'b1, 16'h0011});
        send_cmd(1'b0, 10'h012, 16'h0011, 16'h0000);
        recv_req(3, 1'b0, cyc);
        k = 1;
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycle", k, 17);
        expect_rsp("timeout", 1'b1, 1'b1, 16'h0000);
        // Late response while idle is discarded.
        send_word(16'h0005, 1'b0);
        send_word(16'h0012, 1'b0);
        send_word(16'h4000, 1'b1);
        @(negedge clk);
        check("late_rsp_dropped", {rsp_valid, cmd_ready, debug_in_ready}, {29'h0, 3'b011});

        // Reset while the address word is on the ring
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h0405});
        send_cmd(1'b0, 10'h012, 16'h0021, 16'h0000);
        recv_req(2, 1'b0, cyc);
        check("pre_rst_addr_word", {debug_out_valid, debug_out_data}, {15'h0, 1'b1, 16'h0021});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_out_valid", debug_out_valid, 0);
        check("post_rst_out_data", debug_out_data, 16'h0000);

        // Normal read after the reset
        exp_q.push_back({1'b0, 16'h0012});
        exp_q.push_back({1'b0, 16'h0405});
        exp_q.push_back({1'b1, 16'h0020});
        send_cmd(1'b0, 10'h012, 16'h0020, 16'h0000);
        recv_req(3, 1'b0, cyc);
        send_word(16'h0005, 1'b0);
        send_word(16'h0012, 1'b0);
        send_word(16'hBEEF, 1'b1);
        expect_rsp("after_rst", 1'b0, 1'b0, 16'hBEEF);

        check("exp_q_empty", exp_q.size(), 0);

        // Report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
